// File: rtl/sender_rsa_pack_multi.sv
// sender_rsa_pack_multi
// Multi-channel sender-side RSA packing block. Each of NUM_CH channels forms
// a blinded base (message ^ rand_val ^ received_data, reduced once by N) and
// raises it to d mod N on one shared RL_binary engine. The channels are run
// one after another, then all results appear on packed_data together with a
// one-cycle gen_end pulse.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   gen               start request, only honoured while idle
//   message, rand_val NUM_CH packed WIDTH-bit words, channel i at [i*WIDTH +: WIDTH]
//   N, d              modulus and private exponent
//   received_data     peer value shared by all channels
//   packed_data       results, same packing as message
//   gen_end           one-cycle completion pulse
//   busy              job in progress (through the gen_end cycle)
//   err               rejected-modulus pulse (only with SENDER_PACK_NCHK_EN)
//
// Optional feature macro: SENDER_PACK_NCHK_EN
//   Defined:   a latched N below 2 skips the engine and finishes with zero
//              results and err pulsing alongside gen_end.
//   Undefined: err is tied low and N goes to the engine unchecked.

// RL_binary: right-to-left binary modular exponentiation, r = base^exp mod modulus.
// Each exponent bit costs one bit-serial pass over WIDTH cycles in which the
// square (b*b) and the conditional multiply (res*b) are accumulated side by side.
// Operands are expected to be already below the modulus.
module RL_binary #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             md_start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] r,
    output logic             md_end
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {E_IDLE, E_LOAD, E_MUL, E_UPD, E_DONE} eng_state_t;

    eng_state_t       eng_state;
    logic [WIDTH-1:0] cur_base;
    logic [WIDTH-1:0] cur_exp;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_s;
    logic [CW-1:0]    cnt;

    // One MSB-first interleaved step: p <- (2p + bit*a) mod m, with p, a < m.
    // One extra bit of headroom keeps 2p and p+a from overflowing.
    function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] p_in,
                                                  input logic [WIDTH-1:0] a_in,
                                                  input logic [WIDTH-1:0] m_in,
                                                  input logic             bit_in);
        logic [WIDTH:0] t;
        t = {p_in, 1'b0};
        if (t >= {1'b0, m_in}) t = t - {1'b0, m_in};
        if (bit_in) begin
            t = t + {1'b0, a_in};
            if (t >= {1'b0, m_in}) t = t - {1'b0, m_in};
        end
        return t[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            eng_state <= E_IDLE;
            cur_base  <= '0;
            cur_exp   <= '0;
            res       <= '0;
            mod_q     <= '0;
            acc_r     <= '0;
            acc_s     <= '0;
            cnt       <= '0;
            r         <= '0;
            md_end    <= 1'b0;
        end else begin
            case (eng_state)
                E_IDLE: begin
                    md_end <= 1'b0;
                    if (md_start) begin
                        cur_base  <= base;
                        cur_exp   <= exp;
                        mod_q     <= modulus;
                        res       <= WIDTH'(1);
                        eng_state <= E_LOAD;
                    end
                end
                E_LOAD: begin
                    if (cur_exp == '0) begin
                        r         <= res;
                        md_end    <= 1'b1;
                        eng_state <= E_DONE;
                    end else begin
                        acc_r     <= '0;
                        acc_s     <= '0;
                        cnt       <= CW'(WIDTH - 1);
                        eng_state <= E_MUL;
                    end
                end
                E_MUL: begin
                    // cur_base is the multiplier for both products
                    acc_r <= mod_step(acc_r, res, mod_q, cur_base[cnt]);
                    acc_s <= mod_step(acc_s, cur_base, mod_q, cur_base[cnt]);
                    if (cnt == '0) eng_state <= E_UPD;
                    else           cnt <= cnt - CW'(1);
                end
                E_UPD: begin
                    if (cur_exp[0]) res <= acc_r;
                    cur_base  <= acc_s;
                    cur_exp   <= cur_exp >> 1;
                    eng_state <= E_LOAD;
                end
                E_DONE: begin
                    md_end    <= 1'b0;
                    eng_state <= E_IDLE;
                end
                default: eng_state <= E_IDLE;
            endcase
        end
    end
endmodule

module sender_rsa_pack_multi #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    gen,
    input  logic [NUM_CH*WIDTH-1:0] message,
    input  logic [NUM_CH*WIDTH-1:0] rand_val,
    input  logic [WIDTH-1:0]        N,
    input  logic [WIDTH-1:0]        d,
    input  logic [WIDTH-1:0]        received_data,
    output logic [NUM_CH*WIDTH-1:0] packed_data,
    output logic                    gen_end,
    output logic                    busy,
    output logic                    err
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {IDLE, PREP, START, WAIT, STORE, DONE} state_t;

    state_t                  state;
    logic [CHW-1:0]          ch;
    logic [NUM_CH*WIDTH-1:0] msg_sh;
    logic [NUM_CH*WIDTH-1:0] rnd_sh;
    logic [WIDTH-1:0]        n_sh;
    logic [WIDTH-1:0]        d_sh;
    logic [WIDTH-1:0]        rx_sh;
    logic [WIDTH-1:0]        base_reg;
    logic [WIDTH-1:0]        exp_reg;
    logic [WIDTH-1:0]        mod_reg;
    logic                    md_start;
    logic [WIDTH-1:0]        eng_r;
    logic                    md_end;
    logic [WIDTH-1:0]        result_buf [NUM_CH];
    logic [WIDTH-1:0]        t_val;

    // Blinded value of the channel currently being prepared
    assign t_val = msg_sh[int'(ch)*WIDTH +: WIDTH] ^ rnd_sh[int'(ch)*WIDTH +: WIDTH] ^ rx_sh;

    RL_binary #(.WIDTH(WIDTH)) engine (
        .clk      (clk),
        .rstn     (~rst),
        .md_start (md_start),
        .base     (base_reg),
        .exp      (exp_reg),
        .modulus  (mod_reg),
        .r        (eng_r),
        .md_end   (md_end)
    );

`ifndef SENDER_PACK_NCHK_EN
    assign err = 1'b0;
`endif

    // Outputs are registered on the transition into DONE so that gen_end,
    // busy and packed_data all line up in the DONE cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= '0;
            msg_sh      <= '0;
            rnd_sh      <= '0;
            n_sh        <= '0;
            d_sh        <= '0;
            rx_sh       <= '0;
            base_reg    <= '0;
            exp_reg     <= '0;
            mod_reg     <= '0;
            md_start    <= 1'b0;
            packed_data <= '0;
            gen_end     <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) result_buf[i] <= '0;
`ifdef SENDER_PACK_NCHK_EN
            err         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gen) begin
                        msg_sh <= message;
                        rnd_sh <= rand_val;
                        n_sh   <= N;
                        d_sh   <= d;
                        rx_sh  <= received_data;
                        ch     <= '0;
                        busy   <= 1'b1;
                        state  <= PREP;
                    end
                end
                PREP: begin
`ifdef SENDER_PACK_NCHK_EN
                    if (n_sh < WIDTH'(2)) begin
                        packed_data <= '0;
                        gen_end     <= 1'b1;
                        err         <= 1'b1;
                        state       <= DONE;
                    end else
`endif
                    begin
                        // Single conditional subtract; exact only for t < 2N
                        base_reg <= (t_val >= n_sh) ? t_val - n_sh : t_val;
                        exp_reg  <= d_sh;
                        mod_reg  <= n_sh;
                        md_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    md_start <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (md_end) begin
                        result_buf[ch] <= eng_r;
                        state          <= STORE;
                    end
                end
                STORE: begin
                    if (ch == CHW'(NUM_CH - 1)) begin
                        for (int i = 0; i < NUM_CH; i++)
                            packed_data[i*WIDTH +: WIDTH] <= result_buf[i];
                        gen_end <= 1'b1;
                        state   <= DONE;
                    end else begin
                        ch    <= ch + CHW'(1);
                        state <= PREP;
                    end
                end
                DONE: begin
                    gen_end <= 1'b0;
                    busy    <= 1'b0;
`ifdef SENDER_PACK_NCHK_EN
                    err     <= 1'b0;
`endif
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sender_rsa_pack_multi.sv
// tb_sender_rsa_pack_multi
// Directed bench for sender_rsa_pack_multi (WIDTH=32, NUM_CH=2). Expected
// values are hand-derived RSA constants (3233 = 61*53, e=17, d=2753) plus a
// small 64-bit modular exponentiation model for the non-textbook cases.
module tb_sender_rsa_pack_multi;
    localparam int W  = 32;
    localparam int NC = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            gen;
    logic [NC*W-1:0] message;
    logic [NC*W-1:0] rand_val;
    logic [W-1:0]    N;
    logic [W-1:0]    d;
    logic [W-1:0]    received_data;
    logic [NC*W-1:0] packed_data;
    logic            gen_end;
    logic            busy;
    logic            err;

    int tests = 0;
    int fails = 0;
    int md_start_count = 0;

    sender_rsa_pack_multi #(.WIDTH(W), .NUM_CH(NC)) dut (
        .clk           (clk),
        .rst           (rst),
        .gen           (gen),
        .message       (message),
        .rand_val      (rand_val),
        .N             (N),
        .d             (d),
        .received_data (received_data),
        .packed_data   (packed_data),
        .gen_end       (gen_end),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Counts engine start pulses so aborted or skipped jobs can be confirmed
    always @(posedge clk) if (dut.md_start === 1'b1) md_start_count++;

    function automatic longint model_exp(input longint b, input longint e, input longint m);
        longint r;
        r = 1;
        b = b % m;
        while (e > 0) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic longint model_base(input longint t, input longint n);
        return (t >= n) ? t - n : t;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] m0, input logic [W-1:0] r0,
                                 input logic [W-1:0] m1, input logic [W-1:0] r1,
                                 input logic [W-1:0] nn, input logic [W-1:0] dd,
                                 input logic [W-1:0] rx);
        message       = {m1, m0};
        rand_val      = {r1, r0};
        N             = nn;
        d             = dd;
        received_data = rx;
    endtask

    task automatic startJob;
        gen = 1'b1;
        tick;
        gen = 1'b0;
    endtask

    // Advances until gen_end is seen (bounded), tracking busy on every cycle
    task automatic waitGenEnd(input string tag, input int budget);
        bit seen;
        bit busy_low;
        seen     = 1'b0;
        busy_low = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (busy !== 1'b1) busy_low = 1'b1;
            tick;
            if (gen_end === 1'b1) seen = 1'b1;
        end
        if (busy !== 1'b1) busy_low = 1'b1;
        checkOutput({tag, " gen_end seen"}, 64'(seen), 64'd1);
        checkOutput({tag, " busy held"}, 64'(busy_low), 64'd0);
    endtask

    initial begin
        int pulses;
        int starts_before;
        longint exp1;

        rst = 1'b1;
        gen = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        rst = 1'b0;
        checkOutput("reset packed_data", 64'(packed_data), 64'd0);
        checkOutput("reset gen_end", 64'(gen_end), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset err", 64'(err), 64'd0);

        // Textbook decrypt on both channels, channel 1 blinded by rand 5
        applyStimulus(2790, 0, 2790 ^ 5, 5, 3233, 2753, 0);
        startJob;
        waitGenEnd("decrypt", 5000);
        checkOutput("decrypt ch0", 64'(packed_data[W-1:0]), 64'd65);
        checkOutput("decrypt ch1", 64'(packed_data[2*W-1:W]), 64'd65);
        checkOutput("decrypt err", 64'(err), 64'd0);
        tick;
        checkOutput("decrypt gen_end single", 64'(gen_end), 64'd0);
        checkOutput("decrypt busy after", 64'(busy), 64'd0);

        // Abort during channel 1's engine run
        startJob;
        repeat (600) tick;
        checkOutput("abort busy before rst", 64'(busy), 64'd1);
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        checkOutput("abort packed_data", 64'(packed_data), 64'd0);
        checkOutput("abort gen_end", 64'(gen_end), 64'd0);
        checkOutput("abort busy", 64'(busy), 64'd0);
        starts_before = md_start_count;
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            tick;
            if (gen_end === 1'b1) pulses++;
        end
        checkOutput("abort no md_start", 64'(md_start_count - starts_before), 64'd0);
        checkOutput("abort no gen_end", 64'(pulses), 64'd0);

        // Encrypt, channel 1 base needs the conditional subtract (6023-3233)
        applyStimulus(65, 0, 6023, 0, 3233, 17, 0);
        exp1 = model_exp(model_base(6023, 3233), 17, 3233);
        startJob;
        waitGenEnd("encrypt", 5000);
        checkOutput("encrypt ch0", 64'(packed_data[W-1:0]), 64'd2790);
        checkOutput("encrypt ch1", 64'(packed_data[2*W-1:W]), 64'(exp1));

        // Zero exponent, plus a second gen pulsed while the engine runs
        applyStimulus(100, 7, 32'h0000ABCD, 32'h00001111, 3233, 0, 32'h22);
        startJob;
        tick;
        tick;
        gen = 1'b1;
        tick;
        gen = 1'b0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            if (gen_end === 1'b1) pulses++;
            tick;
        end
        checkOutput("zero-exp gen_end count", 64'(pulses), 64'd1);
        checkOutput("zero-exp ch0", 64'(packed_data[W-1:0]), 64'd1);
        checkOutput("zero-exp ch1", 64'(packed_data[2*W-1:W]), 64'd1);
        checkOutput("zero-exp busy idle", 64'(busy), 64'd0);

        // Back-to-back with gen held; inputs change right after acceptance
        applyStimulus(65, 0, 123, 0, 3233, 17, 0);
        gen = 1'b1;
        tick;
        applyStimulus(2790 ^ 32'h55, 0, 1000, 0, 3233, 2753, 32'h55);
        waitGenEnd("b2b job1", 5000);
        checkOutput("b2b job1 ch0", 64'(packed_data[W-1:0]), 64'd2790);
        checkOutput("b2b job1 ch1", 64'(packed_data[2*W-1:W]), 64'(model_exp(123, 17, 3233)));
        tick;
        checkOutput("b2b idle busy", 64'(busy), 64'd0);
        tick;
        checkOutput("b2b restart busy", 64'(busy), 64'd1);
        gen = 1'b0;
        waitGenEnd("b2b job2", 5000);
        checkOutput("b2b job2 ch0", 64'(packed_data[W-1:0]), 64'd65);
        checkOutput("b2b job2 ch1", 64'(packed_data[2*W-1:W]),
                    64'(model_exp(model_base(1000 ^ 32'h55, 3233), 2753, 3233)));
        tick;

`ifdef SENDER_PACK_NCHK_EN
        // Rejected modulus: no engine start, gen_end and err together
        begin
            bit seen;
            bit err_at_end;
            seen       = 1'b0;
            err_at_end = 1'b0;
            applyStimulus(5, 0, 6, 0, 1, 17, 0);
            starts_before = md_start_count;
            startJob;
            for (int i = 0; i < 3 && !seen; i++) begin
                tick;
                if (gen_end === 1'b1) begin
                    seen       = 1'b1;
                    err_at_end = err;
                end
            end
            checkOutput("nchk gen_end", 64'(seen), 64'd1);
            checkOutput("nchk err", 64'(err_at_end), 64'd1);
            checkOutput("nchk packed_data", 64'(packed_data), 64'd0);
            tick;
            checkOutput("nchk err pulse", 64'(err), 64'd0);
            checkOutput("nchk no md_start", 64'(md_start_count - starts_before), 64'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
